key_debounce: RTL and testbench
===============================

# key_debounce

Debounces the raw active-low push-button input and emits a single-cycle `key_pulse` for every accepted press and every accepted release. It sits directly upstream of the key toggle counter, which advances its LED mode once per two pulses, i.e. once per full press/release cycle. A 2-FF synchronizer and a filter state machine with a hold counter guarantee exactly one pulse per physical edge, regardless of contact bounce.

## Interface
Parameters:
- `DEBOUNCE_CNT`, default 1_000_000: stable-level hold time in clock cycles (20 ms at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default 20: counter width. It must satisfy 2^CNT_W ≥ DEBOUNCE_CNT.

Ports:
- `sys_clk`  in  1: system clock, all logic on its rising edge.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `key_in`  in  1: raw button, asynchronous to `sys_clk`. 0 = pressed.
- `key_pulse`  out  1: one-cycle pulse on each accepted press or release.
- `key_press`  out  1: one-cycle pulse on an accepted press only.
- `key_release`  out  1: one-cycle pulse on an accepted release only.
- `key_state`  out  1: debounced level. 1 = pressed.

## Operation
Synchronizer:
- Two flops, `key_in` → `sync1` → `sync2`. Both reset to 1 (released).
- `key_sync` = `sync2`. The FSM uses only `key_sync`.

FSM states: `IDLE` (stable released), `PRESS_FLT`, `DOWN` (stable pressed), `RELEASE_FLT`. Reset state is `IDLE`.
- `IDLE`: if `key_sync`=0, go to `PRESS_FLT` and set `cnt`←0.
- `PRESS_FLT`:
  - If `key_sync`=1, return to `IDLE` and set `cnt`←0. This rejects the bounce and emits no pulse.
  - Else if `cnt`==DEBOUNCE_CNT-1, go to `DOWN`, set `cnt`←0, `key_state`←1, and pulse `key_press` and `key_pulse` for one cycle.
  - Otherwise `cnt`←`cnt`+1.
- `DOWN`: if `key_sync`=1, go to `RELEASE_FLT` and set `cnt`←0.
- `RELEASE_FLT`: same as `PRESS_FLT` with polarity inverted.
  - If `key_sync`=0, return to `DOWN` with no pulse.
  - On reaching DEBOUNCE_CNT-1 with `key_sync`=1, go to `IDLE`, set `key_state`←0, and pulse `key_release` and `key_pulse`.

Counter and output rules:
- `cnt` is CNT_W bits and never wraps. It is cleared on every state entry and saturates by construction at DEBOUNCE_CNT-1.
- All outputs are registered; none is a combinational decode of state.
- `key_pulse` = `key_press` OR `key_release`. The two are never asserted together.

Reset:
- Reset values: `key_pulse`=0, `key_press`=0, `key_release`=0, `key_state`=0, `cnt`=0, both sync flops =1.
- Reset asserted mid-filter or while `DOWN` returns immediately to `IDLE` with no pulse.
- If the key is still held after reset release, it is re-detected as a new press after the full filter time.

## Timing
- Latency, with edge N = first clock edge sampling `key_in`=0 and `key_in` then held low:
  - `sync2`=0 after edge N+1.
  - `PRESS_FLT` entered on edge N+2.
  - `key_pulse` is high for exactly the cycle following edge N+2+DEBOUNCE_CNT.
- Release latency is identical, measured from the first edge sampling `key_in`=1.
- Glitch rejection:
  - Any excursion of `key_sync` shorter than DEBOUNCE_CNT cycles produces no pulse, and `key_state` does not change.
  - Each re-bounce restarts the count from 0.
- Pulse spacing:
  - `key_pulse` is never high on consecutive cycles.
  - The minimum spacing between two pulses is DEBOUNCE_CNT+1 cycles.
  - Pulses strictly alternate press, release, press, ...
- `key_state` changes on the same edge that raises the corresponding pulse.

## Test plan
All scenarios use DEBOUNCE_CNT=10, CNT_W=4.
- Reset: hold `sys_rst_n`=0 with `key_in` toggling → all outputs 0 and the state stays `IDLE`.
- Clean press: drive `key_in` 1→0 sampled at edge N and hold → one `key_pulse` and one `key_press` after edge N+12, and `key_state`=1 from then on.
- Bounce reject: low for 5 cycles, high for 3, low for 7, then high → zero pulses and `key_state` stays 0.
- Bounce then settle: press with four sub-10-cycle bounces, then a steady low → exactly one pulse, occurring 12 edges after the last 1→0 transition is sampled.
- Full cycle ×2: two press/release cycles of 30 cycles each → 4 `key_pulse`s ordered press, release, press, release. A downstream toggle model advances 0→1→2.
- Reset mid-filter: assert reset with `cnt`=6 in `PRESS_FLT`, release it with the key still low → no pulse before reset. After reset release a fresh press pulse appears 12 edges later.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF synchronizer, then a hold-count filter FSM.
// Emits one registered pulse per accepted press and per accepted release.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   key_in      in   raw button, async to sys_clk, 0 = pressed
//   key_pulse   out  one-cycle pulse on accepted press or release
//   key_press   out  one-cycle pulse on accepted press
//   key_release out  one-cycle pulse on accepted release
//   key_state   out  debounced level, 1 = pressed
module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 1_000_000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_pulse,
    output logic key_press,
    output logic key_release,
    output logic key_state
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FLT,
        DOWN,
        RELEASE_FLT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             key_sync;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             pulse_q;

    // Both flops reset to the released level so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign key_sync = sync2_q;

    // Filter states count consecutive samples of the new level; any sample
    // of the old level aborts back to the stable state, so every re-bounce
    // restarts the hold time from zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_sync) begin
                    state_d = PRESS_FLT;
                    cnt_d   = '0;
                end
            end
            PRESS_FLT: begin
                if (key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_sync) begin
                    state_d = RELEASE_FLT;
                    cnt_d   = '0;
                end
            end
            RELEASE_FLT: begin
                if (!key_sync) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            pulse_q   <= press_d | release_d;
        end
    end

    assign key_pulse   = pulse_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_state   = level_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (DEBOUNCE_CNT=10, CNT_W=4).
// Per-cycle reference model plus table-driven segments and corner sequences.
module tb_key_debounce;

    localparam int D = 10;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_in = 1'b1;
    logic key_pulse;
    logic key_press;
    logic key_release;
    logic key_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press = 0;
    int n_rel = 0;

    // Reference: key_in delayed two edges, then a run-length rule: the
    // debounced level flips once D+1 consecutive samples disagree with it.
    logic m_d1 = 1'b1;
    logic m_d2 = 1'b1;
    logic m_lvl = 1'b1;
    int   m_run = 0;
    logic m_pr = 1'b0;
    logic m_rl = 1'b0;

    typedef struct {
        logic key;
        int   len;
        int   np;
        int   nr;
        logic st;
        int   off;
        bit   fc;
    } seg_t;

    seg_t tbl[$];

    key_debounce #(
        .DEBOUNCE_CNT(D),
        .CNT_W(4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_in(key_in),
        .key_pulse(key_pulse),
        .key_press(key_press),
        .key_release(key_release),
        .key_state(key_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic k, input logic r);
        logic s;
        logic [3:0] act;
        logic [3:0] exp;
        @(negedge sys_clk);
        key_in = k;
        sys_rst_n = r;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (!r) begin
            m_d1 = 1'b1;
            m_d2 = 1'b1;
            m_lvl = 1'b1;
            m_run = 0;
            m_pr = 1'b0;
            m_rl = 1'b0;
        end else begin
            s = m_d2;
            m_d2 = m_d1;
            m_d1 = k;
            m_pr = 1'b0;
            m_rl = 1'b0;
            if (s != m_lvl) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_lvl = s;
                m_run = 0;
                m_pr = ~s;
                m_rl = s;
            end
        end
        n_press += int'(key_press);
        n_rel += int'(key_release);
        act = {key_pulse, key_press, key_release, key_state};
        exp = {m_pr | m_rl, m_pr, m_rl, ~m_lvl};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle %0d outs got %b want %b", cyc, act, exp);
        end
    endtask

    // First tick samples key_in=0 at edge N; pulse expected after edge N+12.
    task automatic press_window(input string name);
        int n0;
        int got;
        int cnt;
        n0 = cyc + 1;
        got = -1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b1);
            if (key_pulse) begin
                cnt++;
                if (got < 0) got = cyc - n0;
            end
        end
        check_int({name, "_latency"}, got, D + 2);
        check_int({name, "_count"}, cnt, 1);
        check_int({name, "_state"}, int'(key_state), 1);
    endtask

    initial begin
        int pre;
        int fc_pulses;
        int total;

        tbl.push_back('{1'b1, 30, 0, 1, 1'b0, 12, 1'b0});
        tbl.push_back('{1'b0, 5, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b1, 3, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b0, 7, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b1, 20, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b0, 4, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b0, 6, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b1, 3, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b0, 8, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b1, 1, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b0, 9, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b1, 2, 0, 0, 1'b0, -1, 1'b0});
        tbl.push_back('{1'b0, 30, 1, 0, 1'b1, 12, 1'b0});
        tbl.push_back('{1'b1, 5, 0, 0, 1'b1, -1, 1'b0});
        tbl.push_back('{1'b0, 3, 0, 0, 1'b1, -1, 1'b0});
        tbl.push_back('{1'b1, 30, 0, 1, 1'b0, 12, 1'b0});
        tbl.push_back('{1'b0, 30, 1, 0, 1'b1, 12, 1'b1});
        tbl.push_back('{1'b1, 30, 0, 1, 1'b0, 12, 1'b1});
        tbl.push_back('{1'b0, 30, 1, 0, 1'b1, 12, 1'b1});
        tbl.push_back('{1'b1, 30, 0, 1, 1'b0, 12, 1'b1});

        for (int i = 0; i < 8; i++) tick(logic'(i % 2), 1'b0);
        check_int("reset_outs",
            int'({key_pulse, key_press, key_release, key_state}), 0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        check_int("idle_outs",
            int'({key_pulse, key_press, key_release, key_state}), 0);

        press_window("clean_press");

        fc_pulses = 0;
        foreach (tbl[i]) begin
            int p0;
            int r0;
            int off;
            p0 = n_press;
            r0 = n_rel;
            off = -1;
            for (int j = 0; j < tbl[i].len; j++) begin
                tick(tbl[i].key, 1'b1);
                if (key_pulse && off < 0) off = j;
            end
            check_int($sformatf("seg%0d_press", i), n_press - p0, tbl[i].np);
            check_int($sformatf("seg%0d_release", i), n_rel - r0, tbl[i].nr);
            check_int($sformatf("seg%0d_state", i), int'(key_state),
                int'(tbl[i].st));
            if (tbl[i].off >= 0)
                check_int($sformatf("seg%0d_offset", i), off, tbl[i].off);
            if (tbl[i].fc) fc_pulses += (n_press - p0) + (n_rel - r0);
        end
        check_int("full_cycle_pulses", fc_pulses, 4);
        check_int("toggle_count", fc_pulses / 2, 2);

        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        pre = n_press + n_rel;
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check_int("mid_filter_no_pulse", n_press + n_rel - pre, 0);
        check_int("mid_filter_state", int'(key_state), 0);
        press_window("after_reset");

        total = 0;
        while (total < 3000) begin
            logic lv;
            int len;
            lv = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 16);
            for (int j = 0; j < len; j++)
                tick(lv, logic'($urandom_range(0, 299) != 0));
            total += len;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
